// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the CPU-side producer, the transmit FIFO and the UART serializer.
// Both sides use valid/ready: a byte moves on a clock edge where valid && ready are both high.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] enq_data;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] deq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [CW-1:0]    count;
    logic             overflow;

    modport master (
        output enq_data, enq_valid, deq_ready,
        input  enq_ready, deq_data, deq_valid, count, overflow
    );

    modport slave (
        input  enq_data, enq_valid, deq_ready,
        output enq_ready, deq_data, deq_valid, count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue in front of the UART serializer, with occupancy count and sticky overflow.
// Optional same-cycle bypass when empty: define UART_TX_FIFO_BYPASS_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic empty, full, push, pop, wr_en, rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push  = bus.enq_valid && !full;
    assign pop   = bus.deq_valid && bus.deq_ready;

`ifdef UART_TX_FIFO_BYPASS_EN
    logic bypass;
    assign bypass        = empty && bus.enq_valid;
    assign bus.deq_valid = !empty || bus.enq_valid;
    assign bus.deq_data  = empty ? bus.enq_data : mem_q[rd_ptr_q[AW-1:0]];
    // A byte consumed straight through never touches storage.
    assign wr_en         = push && !(bypass && bus.deq_ready);
    assign rd_en         = pop && !empty;
`else
    assign bus.deq_valid = !empty;
    assign bus.deq_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_en         = push;
    assign rd_en         = pop;
`endif

    assign bus.enq_ready = !full;
    assign bus.count     = wr_ptr_q - rd_ptr_q;
    assign bus.overflow  = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_en};
        overflow_d = overflow_q || (bus.enq_valid && full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.enq_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clk;
    logic reset;

    uart_tx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] popped_q[$];
    logic             exp_ovf;
    int               n_checks;
    int               n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare settled outputs, advance the model.
    task automatic step(input logic ev, input logic [WIDTH-1:0] d, input logic dr);
        int               size;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic             do_pop;
        logic             do_push;
        @(negedge clk);
        bus.enq_valid = ev;
        bus.enq_data  = d;
        bus.deq_ready = dr;
        #1;
        size      = exp_q.size();
        exp_valid = (size > 0);
        exp_data  = (size > 0) ? exp_q[0] : '0;
`ifdef UART_TX_FIFO_BYPASS_EN
        if (size == 0 && ev) begin
            exp_valid = 1'b1;
            exp_data  = d;
        end
`endif
        check("enq_ready", 32'(bus.enq_ready), 32'(size < DEPTH));
        check("deq_valid", 32'(bus.deq_valid), 32'(exp_valid));
        check("count", 32'(bus.count), 32'(size));
        check("overflow", 32'(bus.overflow), 32'(exp_ovf));
        if (exp_valid) check("deq_data", 32'(bus.deq_data), 32'(exp_data));

        do_pop  = exp_valid && dr;
        do_push = ev && (size < DEPTH);
        if (ev && size == DEPTH) exp_ovf = 1'b1;
        if (do_pop) begin
            popped_q.push_back(bus.deq_data);
            if (size > 0) void'(exp_q.pop_front());
        end
        if (do_push && !(size == 0 && do_pop)) exp_q.push_back(d);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        check("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int tx_busy;
        int base;
        logic [WIDTH-1:0] ref_bytes [2];
        n_checks      = 0;
        n_errors      = 0;
        exp_ovf       = 1'b0;
        reset         = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;
        repeat (2) @(negedge clk);
        apply_reset();

        // Single push, held, then popped.
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, '0, 1'b0);
        check("a5_count", 32'(bus.count), 32'd1);
        check("a5_data", 32'(bus.deq_data), 32'hA5);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("a5_gone", 32'(bus.deq_valid), 32'd0);

        // Fill completely, overflow attempt, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b0, '0, 1'b0);
        check("full_count", 32'(bus.count), 32'(DEPTH));
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        popped_q.delete();
        drain();
        check("full_pop_n", 32'(popped_q.size()), 32'(DEPTH));
        for (int i = 0; i < popped_q.size(); i++) check("full_order", 32'(popped_q[i]), 32'(i));
        check("ovf_after_drain", 32'(bus.overflow), 32'd1);
        apply_reset();

        // Half-full with simultaneous push/pop across several pointer wraps.
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        check("wrap_count", 32'(bus.count), 32'(DEPTH / 2));
        drain();

        // Transmitter model: ready only when idle, busy 10 bit-times of 4 cycles per byte.
        popped_q.delete();
        ref_bytes[0] = 8'h48;
        ref_bytes[1] = 8'h69;
        tx_busy = 0;
        for (int c = 0; c < 400 && popped_q.size() < 2; c++) begin
            base = popped_q.size();
            step((c < 2) ? 1'b1 : 1'b0, (c < 2) ? ref_bytes[c] : 8'h00, (tx_busy == 0));
            if (popped_q.size() != base) tx_busy = 40;
            else if (tx_busy > 0) tx_busy--;
        end
        check("tx_n_bytes", 32'(popped_q.size()), 32'd2);
        if (popped_q.size() == 2) begin
            check("tx_byte0", 32'(popped_q[0]), 32'h48);
            check("tx_byte1", 32'(popped_q[1]), 32'h69);
        end

        // Asynchronous reset in the middle of a burst.
        drain();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        step(1'b0, '0, 1'b0);
        check("burst_count", 32'(bus.count), 32'd5);
        apply_reset();

        // Randomized traffic with phases of differing consumer pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 200; i++) begin
                step(($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 99) < (ph * 25 + 15)));
            end
        end
        drain();

`ifdef UART_TX_FIFO_BYPASS_EN
        step(1'b1, 8'h3C, 1'b1);
        step(1'b0, '0, 1'b0);
        check("bypass_count", 32'(bus.count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered transmit queue sitting directly upstream of the UART transmitter: accepts bytes from the CPU/MMIO side via a valid/ready handshake and presents them, oldest first, to the transmitter's `data_in`/`data_in_valid`/`data_in_ready` port. It decouples CPU stores from the ~10 bit-times per character the serializer needs, so software can burst up to `DEPTH` bytes without stalling. It also provides an occupancy count and a sticky overflow flag for the MMIO status register.

## Interface
- `DEPTH`, 8: number of entries; must be a power of two, ≥ 2.
- `WIDTH`, 8: data width in bits.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0, deasserted at 1).
- `enq_data`  in  WIDTH  byte to enqueue.
- `enq_valid`  in  1  producer has a byte.
- `enq_ready`  out  1  FIFO can accept; equals !full.
- `deq_data`  out  WIDTH  oldest byte; drives the transmitter's `data_in`.
- `deq_valid`  out  1  deq_data is valid; drives `data_in_valid`.
- `deq_ready`  in  1  consumer takes the byte; driven by `data_in_ready`.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: set when enq_valid is high while full.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH)+1 bits (extra MSB is the wrap bit).
- empty = (wr_ptr == rd_ptr); full = (low bits equal, MSBs differ); count = wr_ptr − rd_ptr (modulo 2^(ptr width)).
- Push = enq_valid && enq_ready: write mem[wr_ptr low bits], wr_ptr++.
- Pop = deq_valid && deq_ready: rd_ptr++.
- Pointers wrap naturally at 2^(ptr width); no explicit compare-and-clear.
- enq_ready = !full, independent of deq_ready (no push-through on full).
- deq_valid = !empty; deq_data = mem[rd_ptr low bits] (combinational read, first-word fall-through).
- Simultaneous push and pop (neither full nor empty): both occur, count unchanged.
- deq_data is undefined when deq_valid = 0; consumer must not sample it.
- overflow: set on any cycle with enq_valid=1 and full=1; cleared only by reset. The rejected byte is dropped; FIFO contents are unaffected.
- Reset (any time, including mid-burst): wr_ptr=rd_ptr=0, overflow=0; array contents not cleared. Bytes in flight are discarded; a byte already latched by the transmitter is not affected by this block.

## Timing
- Reset values: enq_ready=1, deq_valid=0, count=0, overflow=0; deq_data don't-care.
- Enqueue latency (no bypass): push in cycle N → deq_valid=1 and deq_data = that byte in cycle N+1.
- Pop effect: pop in cycle N → next entry (or deq_valid=0) visible in cycle N+1.
- Full → not full: pop in cycle N → enq_ready=1 in cycle N+1.
- count updates on the edge after push/pop; reflects registered pointers only.
- Handshake: producer must hold enq_data stable while enq_valid=1 and enq_ready=0; deq_valid, once high, stays high with deq_data stable until popped or reset.

## Configuration
- `UART_TX_FIFO_BYPASS_EN` defined: when empty and enq_valid=1, deq_valid=1 combinationally and deq_data=enq_data in the same cycle; if deq_ready=1 in that cycle the byte is consumed without being written (pointers unchanged, count stays 0); if deq_ready=0 it is written normally. Handshake stability rule then propagates producer→consumer.
- Not defined: deq_valid depends only on registered state; one-cycle enqueue latency as above. Default build leaves it undefined.

## Test plan
- Reset then single push 0xA5 at cycle N, deq_ready=0 → deq_valid=1, deq_data=0xA5, count=1 at N+1; deq_ready=1 → count=0, deq_valid=0 next cycle.
- Push DEPTH bytes 0x00..0x07 with deq_ready=0 → enq_ready=0, count=8; pop all → bytes emerge 0x00..0x07 in order.
- Full FIFO, enq_valid=1 data 0xFF for one cycle → overflow=1 and stays 1; subsequent pops never return 0xFF; reset clears overflow.
- Half-full, push and pop every cycle for 3×DEPTH cycles (pointer wrap) → count constant, output sequence matches input order.
- Drive deq_ready from a transmitter model (ready low for 10 bit-times per byte), push 0x48,0x69 back-to-back → serialized in order, no loss.
- Assert reset mid-burst with count=5 → count=0, deq_valid=0, enq_ready=1 immediately (asynchronous); with BYPASS_EN, empty push with deq_ready=1 → byte seen same cycle, count stays 0.
